multdiv_controller: RTL and testbench

- Multi-cycle sequencer for the shared mult/div unit in the CPU.
- Detects R-type mult/div instructions, pulses the unit's start control and stalls PC/fetch until the unit reports ready.
- Hands the result, or an rstatus exception code, to the regfile write port.
- Sits beside the single-cycle opcode decoder. The top level muxes its writeback over the normal ALU/DM writeback when md_wb_sel=1.

---
 rtl/multdiv_controller_pkg.sv | 16 +
 rtl/multdiv_controller_md_timeout_counter.sv | 32 +++
 rtl/multdiv_controller.sv | 127 ++++++++++++
 tb/tb_multdiv_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_controller_pkg.sv
// Shared constants and state encoding for the mult/div sequencer.
package multdiv_controller_pkg;

  localparam logic [4:0]  ALUOP_MULT  = 5'b00110;
  localparam logic [4:0]  ALUOP_DIV   = 5'b00111;
  localparam logic [4:0]  REG_RSTATUS = 5'd30;
  localparam logic [31:0] MULT_EXC    = 32'd4;
  localparam logic [31:0] DIV_EXC     = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/multdiv_controller_md_timeout_counter.sv
// Watchdog counter for the WAIT state; hit flags the last permitted wait cycle.
module md_timeout_counter #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: default assignment first so every path writes count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign hit   = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_controller.sv
// Sequences one multi-cycle mult/div: start pulse, pipeline stall, then a single writeback cycle.
import multdiv_controller_pkg::*;

module multdiv_controller #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_Rtype,
  input  logic [4:0]  aluOp,
  input  logic [4:0]  rd,
  input  logic        data_resultRDY,
  input  logic        data_exception,
  input  logic [31:0] data_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        md_wb_sel,
  output logic        md_wb_en,
  output logic [4:0]  md_wb_rd,
  output logic [31:0] md_wb_data,
  output logic        busy
);

  md_state_e   state_q, state_d;
  logic        op_is_div_q, op_is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic             detect, is_mult, is_div;
  logic             cnt_clr, cnt_en, cnt_hit;
  logic [CNT_W-1:0] dbg_count_unused;

  assign is_mult = (aluOp == ALUOP_MULT);
  assign is_div  = (aluOp == ALUOP_DIV);
  // Gated by reset so the combinational start/stall outputs are quiet while reset is held.
  assign detect  = ~reset & is_Rtype & (is_mult | is_div);

  md_timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (dbg_count_unused),
    .hit   (cnt_hit)
  );

  always_comb begin
    state_d     = state_q;
    op_is_div_d = op_is_div_q;
    rd_d        = rd_q;
    result_d    = result_q;
    exc_d       = exc_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    ctrl_MULT   = 1'b0;
    ctrl_DIV    = 1'b0;
    stall       = 1'b0;
    md_wb_sel   = 1'b0;
    md_wb_en    = 1'b0;
    md_wb_rd    = '0;
    md_wb_data  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (detect) begin
          ctrl_MULT   = is_mult;
          ctrl_DIV    = is_div;
          stall       = 1'b1;
          op_is_div_d = is_div;
          rd_d        = rd;
          cnt_clr     = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // A result arriving on the watchdog cycle still completes normally.
        if (data_resultRDY) begin
          result_d = data_result;
          exc_d    = data_exception;
          state_d  = ST_DONE;
        end else if (cnt_hit) begin
          result_d = '0;
          exc_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        md_wb_sel = 1'b1;
        if (exc_q) begin
          md_wb_en   = 1'b1;
          md_wb_rd   = REG_RSTATUS;
          md_wb_data = op_is_div_q ? DIV_EXC : MULT_EXC;
        end else begin
          md_wb_en   = (rd_q != 5'd0);
          md_wb_rd   = rd_q;
          md_wb_data = result_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_is_div_q <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_is_div_q <= op_is_div_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_controller.sv
// Randomized scoreboard bench for multdiv_controller against a transaction-level reference model.
module tb_multdiv_controller;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        is_Rtype = 1'b0;
  logic [4:0]  aluOp = '0;
  logic [4:0]  rd = '0;
  logic        data_resultRDY = 1'b0;
  logic        data_exception = 1'b0;
  logic [31:0] data_result = '0;
  logic        ctrl_MULT, ctrl_DIV, stall, md_wb_sel, md_wb_en, busy;
  logic [4:0]  md_wb_rd;
  logic [31:0] md_wb_data;

  multdiv_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .is_Rtype       (is_Rtype),
    .aluOp          (aluOp),
    .rd             (rd),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .data_result    (data_result),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .stall          (stall),
    .md_wb_sel      (md_wb_sel),
    .md_wb_en       (md_wb_en),
    .md_wb_rd       (md_wb_rd),
    .md_wb_data     (md_wb_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  cycle_cnt = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor: every writeback the DUT presents must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (md_wb_sel) begin
          if (exp_q.size() == 0) begin
            check("unexpected_wb", 32'd1, 32'd0);
          end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("wb_cycle", cycle_cnt, e.cyc);
            check("wb_en", {31'd0, md_wb_en}, {31'd0, e.en});
            check("wb_rd", {27'd0, md_wb_rd}, {27'd0, e.rd});
            check("wb_data", md_wb_data, e.data);
          end
        end else begin
          check("wb_idle_zero", {md_wb_en, md_wb_rd, md_wb_data[25:0]} | {31'd0, |md_wb_data}, 32'd0);
        end
      end
    end
  end

  // Reference: an op whose RDY arrives n cycles after the start pulse (n<=TIMEOUT)
  // writes back at n+1; otherwise the watchdog writes r30 at TIMEOUT+1.
  task automatic run_op(input bit is_div, input logic [4:0] r, input int n,
                        input bit exc, input logic [31:0] res);
    int  wb_off;
    bit  exp_exc;
    int  pulses_ok = 0, pulses_bad = 0, stalls = 0, pulse_k = -1;
    wb_t e;
    wb_off  = (n <= TIMEOUT) ? n + 1 : TIMEOUT + 1;
    exp_exc = (n <= TIMEOUT) ? exc : 1'b1;
    e.cyc  = cycle_cnt + wb_off;
    e.en   = exp_exc ? 1'b1 : (r != 5'd0);
    e.rd   = exp_exc ? 5'd30 : r;
    e.data = exp_exc ? (is_div ? 32'd5 : 32'd4) : res;
    exp_q.push_back(e);
    // The instruction stays on the decoder outputs while the pipeline is frozen.
    is_Rtype = 1'b1;
    aluOp    = is_div ? 5'b00111 : 5'b00110;
    rd       = r;
    for (int k = 0; k <= wb_off; k++) begin
      data_resultRDY = (n <= TIMEOUT) && (k == n);
      data_exception = data_resultRDY ? exc : 1'($urandom_range(0, 1));
      data_result    = data_resultRDY ? res : $urandom;
      @(negedge clock);
      if (k < wb_off) begin
        if (is_div ? ctrl_DIV : ctrl_MULT) begin pulses_ok++; pulse_k = k; end
        if (is_div ? ctrl_MULT : ctrl_DIV) pulses_bad++;
        if (stall) stalls++;
      end
      @(posedge clock);
      #1;
    end
    data_resultRDY = 1'b0;
    check("start_pulse_count", pulses_ok, 1);
    check("start_pulse_cycle", pulse_k, 0);
    check("wrong_pulse_count", pulses_bad, 0);
    check("stall_cycles", stalls, wb_off);
  endtask

  // Non-mult/div traffic plus stray RDY pulses, all of which must be ignored.
  task automatic idle_cycles(input int m);
    for (int i = 0; i < m; i++) begin
      is_Rtype = 1'($urandom_range(0, 1));
      aluOp    = is_Rtype ? 5'($urandom_range(8, 31)) : 5'b00110;
      rd       = 5'($urandom);
      data_resultRDY = 1'($urandom_range(0, 1));
      data_exception = 1'($urandom_range(0, 1));
      data_result    = $urandom;
      @(negedge clock);
      check("idle_quiet", {28'd0, ctrl_MULT, ctrl_DIV, stall, busy}, 32'd0);
      @(posedge clock);
      #1;
    end
    data_resultRDY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {24'd0, ctrl_MULT, ctrl_DIV, stall, md_wb_sel, md_wb_en, busy, 2'b00}, 32'd0);
    check("reset_wb_bus", {27'd0, md_wb_rd} | md_wb_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    idle_cycles(2);

    run_op(1'b0, 5'd3, 5, 1'b0, 32'h0000_0015);
    idle_cycles(1);
    run_op(1'b1, 5'd7, 3, 1'b1, 32'hdead_beef);
    run_op(1'b0, 5'd12, 4, 1'b1, 32'h1234_5678);
    run_op(1'b0, 5'd0, 2, 1'b0, 32'h0000_00aa);
    run_op(1'b0, 5'd9, TIMEOUT + 1, 1'b0, 32'h0);
    run_op(1'b1, 5'd9, TIMEOUT + 1, 1'b0, 32'h0);
    run_op(1'b0, 5'd11, TIMEOUT - 1, 1'b0, 32'hcafe_0001);
    run_op(1'b1, 5'd13, TIMEOUT, 1'b0, 32'hcafe_0002);
    run_op(1'b0, 5'd1, 1, 1'b0, 32'h0bad_f00d);
    run_op(1'b1, 5'd2, 1, 1'b0, 32'h0000_0777);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 19))
        0, 1:    n = TIMEOUT + 1;
        2:       n = TIMEOUT - 1;
        3:       n = TIMEOUT;
        default: n = $urandom_range(1, 12);
      endcase
      run_op(1'($urandom_range(0, 1)), 5'($urandom), n,
             ($urandom_range(0, 4) == 0), $urandom);
      idle_cycles($urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of WAIT abandons the op.
    is_Rtype = 1'b1;
    aluOp    = 5'b00110;
    rd       = 5'd9;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    #2;
    reset    = 1'b1;
    is_Rtype = 1'b0;
    #1;
    check("async_reset_outputs", {24'd0, ctrl_MULT, ctrl_DIV, stall, md_wb_sel, md_wb_en, busy, 2'b00}, 32'd0);
    check("async_reset_wb_bus", {27'd0, md_wb_rd} | md_wb_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    data_resultRDY = 1'b1;
    data_exception = 1'b1;
    data_result    = 32'h5555_aaaa;
    @(negedge clock);
    check("late_rdy_ignored", {29'd0, stall, busy, md_wb_sel}, 32'd0);
    @(posedge clock);
    #1;
    data_resultRDY = 1'b0;
    idle_cycles(3);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
